dm_be_ram: RTL

- Word-organised data memory directly downstream of the byte-enable generator in the multicycle MIPS datapath.
- Accepts one load or store request at a time, using the 4-bit byte-lane mask computed in the MEM state.
- Runs the access over a configurable number of wait cycles, then pulses ready so the control FSM can leave its memory wait state.
- Store writes only the lanes set in be; load returns the full aligned word. Load extraction/extension is done downstream.

---
 rtl/dm_be_ram_pkg.sv | 30 +++
 rtl/dm_be_ram_if.sv | 27 ++
 rtl/dm_be_array.sv | 47 ++++
 rtl/dm_be_ram.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dm_be_ram_pkg.sv
// dm_be_ram_pkg
// Shared definitions for the byte-enable data memory: FSM state encoding,
// word/lane geometry and the lane write-enable helper. Lane i always maps to
// data bits [8i+7:8i], the same ordering the byte-enable generator uses.
// Ports: none (package).
package dm_be_ram_pkg;

  localparam int DM_WORD_WIDTH = 32;
  localparam int DM_LANES      = 4;
  localparam int DM_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_DONE = 2'd2
  } dm_state_e;

  // Per-lane write strobes: only a store drives lanes, and only those in be.
  function automatic logic [DM_LANES-1:0] dm_lane_we(input logic we,
                                                     input logic [DM_LANES-1:0] be);
    logic [DM_LANES-1:0] lane_s;
    if (we) begin
      lane_s = be;
    end else begin
      lane_s = {DM_LANES{1'b0}};
    end
    return lane_s;
  endfunction

endpackage

// File: rtl/dm_be_ram_if.sv
// dm_be_ram_if
// Request/response bundle between the memory-stage control and dm_be_ram.
// Signals: req, we, addr, be, wdata (requester -> memory);
//          rdata, ready, busy (memory -> requester).
// Modports: master (requester side), slave (memory side).
interface dm_be_ram_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  ready;
  logic                  busy;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ready, busy
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ready, busy
  );
endinterface

// File: rtl/dm_be_array.sv
// dm_be_array
// Byte-writable word storage, 2**ADDR_WIDTH words of DM_WORD_WIDTH bits.
// Ports: clk, rst_n (clears only the read register), wr_lane (per-byte
// write enables), rd_en (capture mem[addr] into rdata), addr, wdata,
// rdata (registered, held between reads).
module dm_be_array
  import dm_be_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DM_LANES-1:0]      wr_lane,
  input  logic                     rd_en,
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic [DM_WORD_WIDTH-1:0] wdata,
  output logic [DM_WORD_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DM_WORD_WIDTH-1:0] mem_r [0:DEPTH-1];
  logic [DM_WORD_WIDTH-1:0] rdata_r;

  // Lane-masked write; storage contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DM_LANES; i++) begin
      if (wr_lane[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Registered read port, cleared by reset, holds its value between loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (rd_en) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dm_be_ram.sv
// dm_be_ram
// Multicycle data memory behind the byte-enable generator. Accepts one
// load/store at a time, waits WAIT_CYCLES cycles, performs the access on the
// DONE edge and pulses ready together with the registered load data.
// Ports: clk, rst_n (async, active-low), bus (dm_be_ram_if.slave:
// req/we/addr/be/wdata in, rdata/ready/busy out).
module dm_be_ram
  import dm_be_ram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_be_ram_if.slave  bus
);

  localparam bit                      HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [DM_CNT_WIDTH-1:0] WAIT_LOAD =
    HAS_WAIT ? DM_CNT_WIDTH'(WAIT_CYCLES - 1) : 4'd0;

  dm_state_e                 state_r, state_nxt_s;
  logic [DM_CNT_WIDTH-1:0]   cnt_r, cnt_nxt_s;
  logic                      ready_r, ready_nxt_s;
  logic                      busy_r, busy_nxt_s;
  logic                      accept_s;
  logic [DM_LANES-1:0]       wr_lane_s;
  logic                      rd_en_s;
  logic                      req_we_r;
  logic [ADDR_WIDTH-1:0]     req_addr_r;
  logic [DM_LANES-1:0]       req_be_r;
  logic [DM_WORD_WIDTH-1:0]  req_wdata_r;
  logic [DM_WORD_WIDTH-1:0]  rdata_s;

  // busy_r is still high in the ready cycle (state already IDLE), so gating
  // on it keeps a request seen during ready from being accepted early.
  assign accept_s = (state_r == DM_IDLE) && bus.req && !busy_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= DM_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      DM_IDLE: begin
        if (accept_s) begin
          state_nxt_s = HAS_WAIT ? DM_WAIT : DM_DONE;
        end else begin
          state_nxt_s = DM_IDLE;
        end
      end
      DM_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = DM_DONE;
        end else begin
          state_nxt_s = DM_WAIT;
        end
      end
      DM_DONE: state_nxt_s = DM_IDLE;
      default: state_nxt_s = DM_IDLE;
    endcase
  end

  // Output/datapath control: counter update, array strobes, next ready/busy.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    wr_lane_s   = 4'b0000;
    rd_en_s     = 1'b0;
    ready_nxt_s = (state_r == DM_DONE);
    busy_nxt_s  = accept_s || (state_r != DM_IDLE);
    case (state_r)
      DM_IDLE: begin
        if (accept_s) begin
          cnt_nxt_s = WAIT_LOAD;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      DM_WAIT: begin
        if (cnt_r != 4'd0) begin
          cnt_nxt_s = cnt_r - 4'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      DM_DONE: begin
        wr_lane_s = dm_lane_we(req_we_r, req_be_r);
        rd_en_s   = !req_we_r;
      end
      default: begin
        cnt_nxt_s = 4'd0;
      end
    endcase
  end

  // Counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      ready_r <= ready_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // Request latch: inputs are frozen at acceptance for the whole access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_r    <= 1'b0;
      req_addr_r  <= '0;
      req_be_r    <= 4'b0000;
      req_wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      req_we_r    <= bus.we;
      req_addr_r  <= bus.addr;
      req_be_r    <= bus.be;
      req_wdata_r <= bus.wdata;
    end else begin
      req_we_r    <= req_we_r;
      req_addr_r  <= req_addr_r;
      req_be_r    <= req_be_r;
      req_wdata_r <= req_wdata_r;
    end
  end

  dm_be_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_lane (wr_lane_s),
    .rd_en   (rd_en_s),
    .addr    (req_addr_r),
    .wdata   (req_wdata_r),
    .rdata   (rdata_s)
  );

  assign bus.rdata = rdata_s;
  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;

endmodule
